// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU op encodings, EX/MEM control bundle
// and the multiplier FSM state type.
package mips_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;
  localparam logic [2:0] ALU_PSB = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic reg_write;
  } ctrl_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Single-cycle ALU for every op except MUL (MUL decodes to zero here;
// the iterative multiplier lives in ex_stage).
module alu
  import mips_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
      ALU_NOR: y = ~(a | b);
      ALU_MUL: y = '0;
      ALU_PSB: y = b;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage with EX/MEM register. Define EX_STAGE_MULT_EN to
// build the 32-cycle shift-add multiplier; otherwise MUL yields 0.
module ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Read_D1_in,
  input  logic [31:0] Read_D2_in,
  input  logic [31:0] Sign_Extend_in,
  input  logic [31:0] PC_adder_in,
  input  logic [4:0]  Ins_2016_in,
  input  logic [4:0]  Ins_1511_in,
  input  logic [2:0]  AluOp_in,
  input  logic        Alusrc_in,
  input  logic        RegDst_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemToReg_in,
  input  logic        MemToWrite_in,
  input  logic        RegWrite_in,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] ALU_Result_out,
  output logic        Zero_out,
  output logic [31:0] Branch_Target_out,
  output logic [31:0] Write_Data_out,
  output logic [4:0]  Write_Reg_out,
  output logic        Branch_out,
  output logic        MemRead_out,
  output logic        MemToReg_out,
  output logic        MemToWrite_out,
  output logic        RegWrite_out
);

  logic [31:0] op_b;
  logic [31:0] alu_y;
  logic [31:0] cap_bt;
  logic [4:0]  cap_wreg;
  ctrl_t       cap_ctrl;

  logic [31:0] res_nx;
  logic [31:0] bt_nx;
  logic [31:0] wd_nx;
  logic [4:0]  wreg_nx;
  ctrl_t       ctrl_nx;

  assign op_b     = Alusrc_in ? Sign_Extend_in : Read_D2_in;
  assign cap_bt   = PC_adder_in + (Sign_Extend_in << 2);
  assign cap_wreg = RegDst_in ? Ins_1511_in : Ins_2016_in;
  assign cap_ctrl = {Branch_in, MemRead_in, MemToReg_in,
                     MemToWrite_in, RegWrite_in};

  alu u_alu (
    .op (AluOp_in),
    .a  (Read_D1_in),
    .b  (op_b),
    .y  (alu_y)
  );

`ifdef EX_STAGE_MULT_EN
  mul_state_t  state, state_nx;
  logic [5:0]  cnt, cnt_nx;
  logic [31:0] mc, mc_nx;
  logic [31:0] mp, mp_nx;
  logic [31:0] acc, acc_nx;
  logic [31:0] l_bt, l_bt_nx;
  logic [31:0] l_wd, l_wd_nx;
  logic [4:0]  l_wreg, l_wreg_nx;
  ctrl_t       l_ctrl, l_ctrl_nx;

  assign busy = (state == S_MUL);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    mc_nx     = mc;
    mp_nx     = mp;
    acc_nx    = acc;
    l_bt_nx   = l_bt;
    l_wd_nx   = l_wd;
    l_wreg_nx = l_wreg;
    l_ctrl_nx = l_ctrl;
    res_nx    = alu_y;
    bt_nx     = cap_bt;
    wd_nx     = Read_D2_in;
    wreg_nx   = cap_wreg;
    ctrl_nx   = cap_ctrl;
    unique case (state)
      S_IDLE: begin
        if (flush) begin
          ctrl_nx = '0;
        end else if (AluOp_in == ALU_MUL) begin
          state_nx  = S_MUL;
          cnt_nx    = '0;
          mc_nx     = Read_D1_in;
          mp_nx     = op_b;
          acc_nx    = '0;
          l_bt_nx   = cap_bt;
          l_wd_nx   = Read_D2_in;
          l_wreg_nx = cap_wreg;
          l_ctrl_nx = cap_ctrl;
          ctrl_nx   = '0;
        end
      end
      S_MUL: begin
        // EX/MEM keeps its data and carries a bubble
        res_nx  = ALU_Result_out;
        bt_nx   = Branch_Target_out;
        wd_nx   = Write_Data_out;
        wreg_nx = Write_Reg_out;
        ctrl_nx = '0;
        acc_nx  = acc + (mp[0] ? mc : 32'd0);
        mc_nx   = mc << 1;
        mp_nx   = mp >> 1;
        cnt_nx  = cnt + 6'd1;
        if (flush)
          state_nx = S_IDLE;
        else if (cnt == 6'd31)
          state_nx = S_DONE;
      end
      S_DONE: begin
        res_nx   = acc;
        bt_nx    = l_bt;
        wd_nx    = l_wd;
        wreg_nx  = l_wreg;
        ctrl_nx  = flush ? '0 : l_ctrl;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mc     <= '0;
      mp     <= '0;
      acc    <= '0;
      l_bt   <= '0;
      l_wd   <= '0;
      l_wreg <= '0;
      l_ctrl <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      mc     <= mc_nx;
      mp     <= mp_nx;
      acc    <= acc_nx;
      l_bt   <= l_bt_nx;
      l_wd   <= l_wd_nx;
      l_wreg <= l_wreg_nx;
      l_ctrl <= l_ctrl_nx;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    res_nx  = alu_y;
    bt_nx   = cap_bt;
    wd_nx   = Read_D2_in;
    wreg_nx = cap_wreg;
    ctrl_nx = flush ? '0 : cap_ctrl;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_Result_out    <= '0;
      Zero_out          <= 1'b0;
      Branch_Target_out <= '0;
      Write_Data_out    <= '0;
      Write_Reg_out     <= '0;
      {Branch_out, MemRead_out, MemToReg_out,
       MemToWrite_out, RegWrite_out} <= '0;
    end else begin
      ALU_Result_out    <= res_nx;
      Zero_out          <= (res_nx == 32'd0);
      Branch_Target_out <= bt_nx;
      Write_Data_out    <= wd_nx;
      Write_Reg_out     <= wreg_nx;
      {Branch_out, MemRead_out, MemToReg_out,
       MemToWrite_out, RegWrite_out} <= ctrl_nx;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table, random ops against a
// reference model, and multiply / reset / flush sequences.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Read_D1_in, Read_D2_in, Sign_Extend_in, PC_adder_in;
  logic [4:0]  Ins_2016_in, Ins_1511_in;
  logic [2:0]  AluOp_in;
  logic        Alusrc_in, RegDst_in;
  logic        Branch_in, MemRead_in, MemToReg_in;
  logic        MemToWrite_in, RegWrite_in, flush;
  logic        busy;
  logic [31:0] ALU_Result_out, Branch_Target_out, Write_Data_out;
  logic        Zero_out;
  logic [4:0]  Write_Reg_out;
  logic        Branch_out, MemRead_out, MemToReg_out;
  logic        MemToWrite_out, RegWrite_out;

  int n_checks = 0;
  int n_errors = 0;

  ex_stage dut (
    .clk               (clk),
    .rst               (rst),
    .Read_D1_in        (Read_D1_in),
    .Read_D2_in        (Read_D2_in),
    .Sign_Extend_in    (Sign_Extend_in),
    .PC_adder_in       (PC_adder_in),
    .Ins_2016_in       (Ins_2016_in),
    .Ins_1511_in       (Ins_1511_in),
    .AluOp_in          (AluOp_in),
    .Alusrc_in         (Alusrc_in),
    .RegDst_in         (RegDst_in),
    .Branch_in         (Branch_in),
    .MemRead_in        (MemRead_in),
    .MemToReg_in       (MemToReg_in),
    .MemToWrite_in     (MemToWrite_in),
    .RegWrite_in       (RegWrite_in),
    .flush             (flush),
    .busy              (busy),
    .ALU_Result_out    (ALU_Result_out),
    .Zero_out          (Zero_out),
    .Branch_Target_out (Branch_Target_out),
    .Write_Data_out    (Write_Data_out),
    .Write_Reg_out     (Write_Reg_out),
    .Branch_out        (Branch_out),
    .MemRead_out       (MemRead_out),
    .MemToReg_out      (MemToReg_out),
    .MemToWrite_out    (MemToWrite_out),
    .RegWrite_out      (RegWrite_out)
  );

  always #5 clk = ~clk;

  logic [4:0] ctrl_o;
  assign ctrl_o = {Branch_out, MemRead_out, MemToReg_out,
                   MemToWrite_out, RegWrite_out};

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, imm, pc;
    logic [4:0]  rt, rd;
    logic        alusrc, regdst, fl;
    logic [4:0]  ctrl;
    logic        chk_data;
    logic [31:0] e_res;
    logic        e_zero;
    logic [31:0] e_bt;
    logic [4:0]  e_wreg;
    logic [4:0]  e_ctrl;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, b,
                       imm, pc, input logic [4:0] rt, rd,
                       input logic alusrc, regdst,
                       input logic [4:0] ctrl, input logic fl);
    AluOp_in = op; Read_D1_in = a; Read_D2_in = b;
    Sign_Extend_in = imm; PC_adder_in = pc;
    Ins_2016_in = rt; Ins_1511_in = rd;
    Alusrc_in = alusrc; RegDst_in = regdst; flush = fl;
    {Branch_in, MemRead_in, MemToReg_in,
     MemToWrite_in, RegWrite_in} = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the op definitions
  function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                          input logic [31:0] a, b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return 32'(a + b);
      3'd1: return 32'(a - b);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (sa < sb) ? 32'd1 : 32'd0;
      3'd5: return ~(a | b);
      3'd6: return 32'd0;
      default: return b;
    endcase
  endfunction

  function automatic vec_t mk(input logic [2:0] op,
                              input logic [31:0] a, b, imm, pc,
                              input logic [4:0] rt, rd,
                              input logic alusrc, regdst, fl,
                              input logic [4:0] ctrl,
                              input logic chk_data,
                              input logic [31:0] e_res,
                              input logic e_zero,
                              input logic [31:0] e_bt,
                              input logic [4:0] e_wreg, e_ctrl);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.imm = imm; v.pc = pc;
    v.rt = rt; v.rd = rd; v.alusrc = alusrc; v.regdst = regdst;
    v.fl = fl; v.ctrl = ctrl; v.chk_data = chk_data;
    v.e_res = e_res; v.e_zero = e_zero; v.e_bt = e_bt;
    v.e_wreg = e_wreg; v.e_ctrl = e_ctrl;
    return v;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, " res"}, ALU_Result_out, 32'd0);
    chk({nm, " zero"}, {31'd0, Zero_out}, 32'd0);
    chk({nm, " bt"}, Branch_Target_out, 32'd0);
    chk({nm, " wd"}, Write_Data_out, 32'd0);
    chk({nm, " wreg"}, {27'd0, Write_Reg_out}, 32'd0);
    chk({nm, " ctrl"}, {27'd0, ctrl_o}, 32'd0);
    chk({nm, " busy"}, {31'd0, busy}, 32'd0);
  endtask

`ifdef EX_STAGE_MULT_EN
  // MUL 0xFFFF * 0x10001, rd=3, RegWrite; inputs scrambled afterwards
  task automatic start_mul();
    drive(3'b110, 32'h0000FFFF, 32'h00010001, 32'd1, 32'h400,
          5'd4, 5'd3, 1'b0, 1'b1, 5'b00001, 1'b0);
    tick();
    chk("mul entry busy", {31'd0, busy}, 32'd1);
    chk("mul entry bubble", {27'd0, ctrl_o}, 32'd0);
    drive(3'b000, 32'd1, 32'd2, 32'd0, 32'h0,
          5'd6, 5'd7, 1'b0, 1'b1, 5'b11111, 1'b0);
  endtask
`endif

  initial begin
    int busy_cycles;
    logic [2:0]  op;
    logic [31:0] a, b, imm, pc, bsel, exp;
    logic [4:0]  rt, rd, ctrl;
    logic        alusrc, regdst, fl;

    rst = 1'b1;
    drive(3'b000, 32'd5, 32'd7, 32'd3, 32'h100,
          5'd1, 5'd9, 1'b0, 1'b1, 5'b11111, 1'b0);
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    vecs.push_back(mk(3'd0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd4, 5'd9,
      0, 1, 0, 5'b00001, 1, 32'd12, 0, 32'd0, 5'd9, 5'b00001));
    vecs.push_back(mk(3'd1, 32'h80000000, 32'd1, 32'd0, 32'h40, 5'd4,
      5'd9, 0, 0, 0, 5'b00001, 1, 32'h7FFFFFFF, 0, 32'h40, 5'd4,
      5'b00001));
    vecs.push_back(mk(3'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd5,
      5'd6, 0, 1, 0, 5'b00001, 1, 32'd1, 0, 32'd0, 5'd6, 5'b00001));
    vecs.push_back(mk(3'd1, 32'h1234, 32'h1234, 32'd3, 32'h100, 5'd2,
      5'd8, 0, 0, 0, 5'b10000, 1, 32'd0, 1, 32'h10C, 5'd2, 5'b10000));
    vecs.push_back(mk(3'd2, 32'hF0F0, 32'h5555, 32'hFFFFFF0F, 32'h200,
      5'd10, 5'd11, 1, 0, 0, 5'b01010, 1, 32'h0000F000, 0,
      32'hFFFFFE3C, 5'd10, 5'b01010));
    vecs.push_back(mk(3'd3, 32'h0F00, 32'h00F0, 32'd0, 32'd4, 5'd1,
      5'd31, 0, 1, 0, 5'b01101, 1, 32'h0FF0, 0, 32'd4, 5'd31,
      5'b01101));
    vecs.push_back(mk(3'd5, 32'd0, 32'd0, 32'd0, 32'd0, 5'd3, 5'd3,
      0, 1, 0, 5'b00001, 1, 32'hFFFFFFFF, 0, 32'd0, 5'd3, 5'b00001));
    vecs.push_back(mk(3'd7, 32'hDEAD, 32'd0, 32'd0, 32'd8, 5'd12,
      5'd13, 0, 0, 0, 5'b00100, 1, 32'd0, 1, 32'd8, 5'd12, 5'b00100));
    vecs.push_back(mk(3'd0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1, 5'd2,
      0, 1, 1, 5'b11111, 0, 32'd0, 0, 32'd0, 5'd0, 5'b00000));
    vecs.push_back(mk(3'd4, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd7,
      5'd8, 0, 0, 0, 5'b00001, 1, 32'd0, 1, 32'd0, 5'd7, 5'b00001));
    vecs.push_back(mk(3'd0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 5'd7,
      5'd8, 0, 0, 0, 5'b00001, 1, 32'd1, 0, 32'd0, 5'd7, 5'b00001));
`ifndef EX_STAGE_MULT_EN
    vecs.push_back(mk(3'd6, 32'd3, 32'd4, 32'd0, 32'd0, 5'd7, 5'd8,
      0, 1, 0, 5'b00001, 1, 32'd0, 1, 32'd0, 5'd8, 5'b00001));
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc,
            vecs[i].rt, vecs[i].rd, vecs[i].alusrc, vecs[i].regdst,
            vecs[i].ctrl, vecs[i].fl);
      tick();
      chk($sformatf("vec%0d ctrl", i), {27'd0, ctrl_o},
          {27'd0, vecs[i].e_ctrl});
      chk($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd0);
      if (vecs[i].chk_data) begin
        chk($sformatf("vec%0d res", i), ALU_Result_out, vecs[i].e_res);
        chk($sformatf("vec%0d zero", i), {31'd0, Zero_out},
            {31'd0, vecs[i].e_zero});
        chk($sformatf("vec%0d bt", i), Branch_Target_out, vecs[i].e_bt);
        chk($sformatf("vec%0d wd", i), Write_Data_out, vecs[i].b);
        chk($sformatf("vec%0d wreg", i), {27'd0, Write_Reg_out},
            {27'd0, vecs[i].e_wreg});
      end
    end

    for (int n = 0; n < 200; n++) begin
      op = 3'($urandom_range(0, 7));
`ifdef EX_STAGE_MULT_EN
      if (op == 3'd6) op = 3'd7;
`endif
      a = $urandom; b = $urandom; imm = $urandom; pc = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      rt = 5'($urandom); rd = 5'($urandom); ctrl = 5'($urandom);
      alusrc = 1'($urandom); regdst = 1'($urandom);
      fl = ($urandom_range(0, 7) == 0);
      drive(op, a, b, imm, pc, rt, rd, alusrc, regdst, ctrl, fl);
      tick();
      bsel = alusrc ? imm : b;
      exp = ref_alu(op, a, bsel);
      chk("rnd busy", {31'd0, busy}, 32'd0);
      chk("rnd ctrl", {27'd0, ctrl_o}, fl ? 32'd0 : {27'd0, ctrl});
      if (!fl) begin
        chk("rnd res", ALU_Result_out, exp);
        chk("rnd zero", {31'd0, Zero_out}, {31'd0, exp == 32'd0});
        chk("rnd bt", Branch_Target_out, 32'(pc + imm * 4));
        chk("rnd wd", Write_Data_out, b);
        chk("rnd wreg", {27'd0, Write_Reg_out},
            {27'd0, regdst ? rd : rt});
      end
    end

`ifdef EX_STAGE_MULT_EN
    start_mul();
    busy_cycles = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!busy) break;
      busy_cycles++;
      chk("mul bubble", {27'd0, ctrl_o}, 32'd0);
    end
    chk("mul busy cycles", busy_cycles, 32'd32);
    chk("mul done bubble", {27'd0, ctrl_o}, 32'd0);
    tick();
    chk("mul res", ALU_Result_out, 32'hFFFFFFFF);
    chk("mul zero", {31'd0, Zero_out}, 32'd0);
    chk("mul ctrl", {27'd0, ctrl_o}, 32'd1);
    chk("mul wreg", {27'd0, Write_Reg_out}, 32'd3);
    chk("mul bt", Branch_Target_out, 32'h404);
    chk("mul wd", Write_Data_out, 32'h00010001);
    chk("mul busy after", {31'd0, busy}, 32'd0);
    tick();
    chk("post mul add", ALU_Result_out, 32'd3);
    chk("post mul ctrl", {27'd0, ctrl_o}, 32'h1F);

    start_mul();
    for (int c = 0; c < 10; c++) tick();
    chk("mid mul busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk_all_zero("mul reset");
    rst = 1'b0;
    tick();
    chk("after reset add", ALU_Result_out, 32'd3);
    chk("after reset busy", {31'd0, busy}, 32'd0);

    start_mul();
    for (int c = 0; c < 5; c++) tick();
    flush = 1'b1;
    tick();
    chk("mul flush busy", {31'd0, busy}, 32'd0);
    chk("mul flush ctrl", {27'd0, ctrl_o}, 32'd0);
    flush = 1'b0;
    tick();
    chk("after flush add", ALU_Result_out, 32'd3);
    chk("after flush ctrl", {27'd0, ctrl_o}, 32'h1F);
`else
    drive(3'b110, 32'h0000FFFF, 32'h00010001, 32'd0, 32'd0,
          5'd4, 5'd3, 1'b0, 1'b1, 5'b00001, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("nomul busy", {31'd0, busy}, 32'd0);
      chk("nomul res", ALU_Result_out, 32'd0);
      chk("nomul ctrl", {27'd0, ctrl_o}, 32'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
